// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two requesting ports, the arbiter and the shared data memory.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface dmem_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 48
);
    logic [AW-1:0] a_addr;
    logic          a_read;
    logic          a_write;
    logic [DW-1:0] a_wdata;
    logic [DW-1:0] a_rdata;
    logic          a_done;
    logic          a_err;

    logic [AW-1:0] b_addr;
    logic          b_read;
    logic          b_write;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] b_rdata;
    logic          b_done;
    logic          b_err;

    logic [AW-1:0] m_addr;
    logic          m_read;
    logic          m_write;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_done;

    logic [1:0]    o_grant;

    modport slave (
        input  a_addr, a_read, a_write, a_wdata,
        output a_rdata, a_done, a_err,
        input  b_addr, b_read, b_write, b_wdata,
        output b_rdata, b_done, b_err,
        output m_addr, m_read, m_write, m_wdata,
        input  m_rdata, m_done,
        output o_grant
    );

    modport master (
        output a_addr, a_read, a_write, a_wdata,
        input  a_rdata, a_done, a_err,
        output b_addr, b_read, b_write, b_wdata,
        input  b_rdata, b_done, b_err,
        input  m_addr, m_read, m_write, m_wdata,
        output m_rdata, m_done,
        input  o_grant
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared data memory: one whole transaction per grant,
// a forced idle cycle between grants, and a timeout abort when the memory never answers.
module dmem_arbiter #(
    parameter int AW      = 15,
    parameter int DW      = 48,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);
    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          last_a, last_a_n;
    logic          req_a, req_b, expire;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
        return (t == T_MAX) ? t : t + 1'b1;
    endfunction

    assign req_a  = bus.a_read | bus.a_write;
    assign req_b  = bus.b_read | bus.b_write;
    assign expire = (timer == T_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            timer  <= '0;
            last_a <= 1'b0;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            last_a <= last_a_n;
        end
    end

    // Every BUSY exit lands in IDLE, which is what guarantees the request gap the memory needs.
    always_comb begin
        state_n  = state;
        timer_n  = '0;
        last_a_n = last_a;
        case (state)
            IDLE: begin
                if (req_a && (!req_b || !last_a)) state_n = BUSY_A;
                else if (req_b)                    state_n = BUSY_B;
            end
            BUSY_A: begin
                if (bus.m_done) begin
                    state_n  = IDLE;
                    last_a_n = 1'b1;
                end else if (!req_a) begin
                    state_n  = IDLE;
                end else if (expire) begin
                    state_n  = IDLE;
                    last_a_n = 1'b1;
                end else begin
                    timer_n  = sat_inc(timer);
                end
            end
            BUSY_B: begin
                if (bus.m_done) begin
                    state_n  = IDLE;
                    last_a_n = 1'b0;
                end else if (!req_b) begin
                    state_n  = IDLE;
                end else if (expire) begin
                    state_n  = IDLE;
                    last_a_n = 1'b0;
                end else begin
                    timer_n  = sat_inc(timer);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.m_addr  = {AW{1'b0}};
        bus.m_wdata = {DW{1'b0}};
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        bus.a_done  = 1'b0;
        bus.a_err   = 1'b0;
        bus.b_done  = 1'b0;
        bus.b_err   = 1'b0;
        // Read data is only meaningful with done, but stays quiet while reset is held.
        bus.a_rdata = reset_n ? bus.m_rdata : {DW{1'b0}};
        bus.b_rdata = reset_n ? bus.m_rdata : {DW{1'b0}};
        bus.o_grant = {state == BUSY_B, state == BUSY_A};
        case (state)
            BUSY_A: begin
                bus.m_addr  = bus.a_addr;
                bus.m_wdata = bus.a_wdata;
                bus.m_write = bus.a_write;
                bus.m_read  = bus.a_read & ~bus.a_write;
                bus.a_done  = bus.m_done;
                bus.a_err   = req_a & ~bus.m_done & expire;
            end
            BUSY_B: begin
                bus.m_addr  = bus.b_addr;
                bus.m_wdata = bus.b_wdata;
                bus.m_write = bus.b_write;
                bus.m_read  = bus.b_read & ~bus.b_write;
                bus.b_done  = bus.m_done;
                bus.b_err   = req_b & ~bus.m_done & expire;
            end
            default: ;
        endcase
    end
endmodule
